// File: rtl/taglist_gen_param.sv
// rtl/taglist_gen_param.sv - parametrised sequence-ROM scanner writing packed tag entries
module taglist_gen_param #(
  parameter int ADDR_W  = 10,
  parameter int SEQ_W   = 7,
  parameter int ROM_LAT = 2
) (
  input  logic              clk_50MHz,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        rom_flags,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [31:0]       ram_data,
  output logic [SEQ_W-1:0]  ram_addr,
  output logic              ram_we,
  output logic              busy,
  output logic              done,
  output logic [SEQ_W:0]    entry_count,
  output logic              wrap_err,
  output logic              seq_ovf
);

  typedef enum logic [1:0] {IDLE, SCAN, WRITE, DONE} state_t;

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
  localparam logic [SEQ_W-1:0]  SEQ_MAX  = '1;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  pipe_addr [ROM_LAT];
  logic [ROM_LAT-1:0] pipe_vld;
  logic [ADDR_W-1:0]  head_addr;
  logic               head_vld;
  logic [1:0]         head_flags;
  logic               issued_last;
  logic [ADDR_W-1:0]  seg_start;
  logic [ADDR_W-1:0]  end_q;
  logic               eof_q;
  logic [SEQ_W-1:0]   seq;
  logic               head_hit;
  logic               head_last;
  logic               seg_close;
  logic               kick;

  function automatic logic [31:0] pack_entry(input logic [SEQ_W-1:0]  s,
                                             input logic [ADDR_W-1:0] st,
                                             input logic [ADDR_W-1:0] en,
                                             input logic              e);
    logic [31:0] p;
    p = '0;
    p[0] = e;
    p[ADDR_W:1] = en;
    p[2*ADDR_W:ADDR_W+1] = st;
    p[2*ADDR_W+SEQ_W:2*ADDR_W+1] = s;
    return p;
  endfunction

  // The head stage pairs a returned address with the flags sampled for it.
  assign head_hit  = head_flags != 2'b00;
  assign head_last = head_addr == ADDR_MAX;
  assign seg_close = head_vld && (head_hit || head_last);
  assign kick      = start && (state_q == IDLE || state_q == DONE);

  assign ram_we = state_q == WRITE;
  assign busy   = state_q == SCAN || state_q == WRITE;
  assign done   = state_q == DONE;

  // Next-state decode: a closed segment costs exactly one WRITE cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = SCAN;
      SCAN:       if (seg_close) state_d = WRITE;
      WRITE:      state_d = (eof_q || seq == SEQ_MAX) ? DONE : SCAN;
      default:    state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_50MHz or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Address issue and read-latency pipeline; a closing segment flushes every in-flight read.
  always_ff @(posedge clk_50MHz or negedge reset) begin
    if (!reset) begin
      rom_addr    <= '0;
      pipe_vld    <= '0;
      head_addr   <= '0;
      head_vld    <= 1'b0;
      head_flags  <= 2'b00;
      issued_last <= 1'b0;
      for (int i = 0; i < ROM_LAT; i++) pipe_addr[i] <= '0;
    end else if (kick) begin
      rom_addr    <= '0;
      pipe_vld    <= '0;
      head_vld    <= 1'b0;
      issued_last <= 1'b0;
    end else if (state_q == SCAN) begin
      if (seg_close) begin
        pipe_vld <= '0;
        head_vld <= 1'b0;
        if (head_hit) begin
          rom_addr    <= head_addr + 1'b1;
          issued_last <= head_last;
        end
      end else begin
        pipe_addr[0] <= rom_addr;
        pipe_vld[0]  <= !issued_last;
        for (int i = 1; i < ROM_LAT; i++) begin
          pipe_addr[i] <= pipe_addr[i-1];
          pipe_vld[i]  <= pipe_vld[i-1];
        end
        head_addr  <= pipe_addr[ROM_LAT-1];
        head_vld   <= pipe_vld[ROM_LAT-1];
        head_flags <= rom_flags;
        if (!issued_last) begin
          if (rom_addr == ADDR_MAX) issued_last <= 1'b1;
          else                      rom_addr    <= rom_addr + 1'b1;
        end
      end
    end
  end

  // Segment bookkeeping; a flag on the last ROM word also ends the scan so it never wraps to 0.
  always_ff @(posedge clk_50MHz or negedge reset) begin
    if (!reset) begin
      seg_start   <= '0;
      end_q       <= '0;
      eof_q       <= 1'b0;
      seq         <= '0;
      ram_data    <= '0;
      ram_addr    <= '0;
      entry_count <= '0;
      wrap_err    <= 1'b0;
      seq_ovf     <= 1'b0;
    end else if (kick) begin
      seg_start   <= '0;
      seq         <= SEQ_W'(1);
      ram_addr    <= '0;
      entry_count <= '0;
      wrap_err    <= 1'b0;
      seq_ovf     <= 1'b0;
    end else if (state_q == SCAN && seg_close) begin
      end_q    <= head_addr;
      eof_q    <= head_flags[0] | head_last;
      wrap_err <= !head_hit;
      ram_data <= pack_entry(seq, seg_start, head_addr, head_flags[0] | head_last);
    end else if (state_q == WRITE) begin
      entry_count <= entry_count + 1'b1;
      ram_addr    <= ram_addr + 1'b1;
      seg_start   <= end_q + 1'b1;
      seq         <= seq + 1'b1;
      if (!eof_q && seq == SEQ_MAX) seq_ovf <= 1'b1;
    end
  end

endmodule

// File: doc/taglist_gen_param.md
Name: taglist_gen_param

Overview:
- Parametrised successor to the single-ROM tag-list generator.
- Scans a sequence ROM through a pipelined read port with a configurable read latency.
- Detects end-of-sequence and end-of-ROM flags, and writes one packed tag entry per sequence into a tag-list RAM, with an explicit write address.
- Adds a start/done handshake for rescans, address-wrap protection, sequence-number overflow detection and an entry count.

Parameters:
- ADDR_W, 10: ROM address width. Also the width of the start and end fields.
- SEQ_W, 7: sequence-number width. Also the RAM write-address width.
- ROM_LAT, 2: cycles from rom_addr to the matching rom_flags. Legal range 1..4.
- Constraint: 2*ADDR_W + SEQ_W + 1 <= 32.

Ports:
- clk_50MHz  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- start  in  1  one-cycle pulse; begins a scan from address 0. Honoured only in IDLE or DONE.
- rom_flags  in  2  bit1 = end-of-sequence, bit0 = end-of-ROM. Valid ROM_LAT cycles after the address is issued.
- rom_addr  out  ADDR_W  ROM read address.
- ram_data  out  32  packed entry:
  - [0] eof
  - [ADDR_W:1] end address
  - [2*ADDR_W:ADDR_W+1] start address
  - [2*ADDR_W+SEQ_W:2*ADDR_W+1] sequence number
  - remaining upper bits 0
- ram_addr  out  SEQ_W  RAM write address; the entry index, starting at 0.
- ram_we  out  1  one-cycle write strobe.
- busy  out  1  high in SCAN and WRITE.
- done  out  1  high in DONE.
- entry_count  out  SEQ_W+1  number of entries written in this scan.
- wrap_err  out  1  ROM end reached without an end-of-ROM flag.
- seq_ovf  out  1  sequence-number space exhausted before end-of-ROM.

Behaviour:
- Reset (asynchronous, reset=0): state IDLE. Every output is 0: rom_addr, ram_data, ram_addr, ram_we, busy, done, entry_count, wrap_err, seq_ovf. Internal pipeline valids are cleared. Reset asserted mid-scan aborts immediately; a partial entry is never written.
- States: IDLE, SCAN, WRITE, DONE.
- IDLE/DONE + start=1, next edge:
  - State becomes SCAN; rom_addr=0; seg_start=0; seq=1.
  - ram_addr=0; entry_count, wrap_err and seq_ovf are cleared.
- SCAN:
  - Each cycle the current rom_addr is pushed into a ROM_LAT-deep address/valid pipeline, and rom_addr increments.
  - After issuing 2^ADDR_W-1, rom_addr holds and no further valid entries are pushed.
  - The pipeline head carries the returned address R and the current rom_flags.
  - Flag evaluation happens only when the pipeline head is valid. In that case:
    - flags != 0: latch end=R and eof=rom_flags[0] (bit0 wins when both bits are set). Flush all pipeline valids. Set rom_addr=R+1. Go to WRITE.
    - flags == 0 and R == 2^ADDR_W-1: latch end=R, eof=1, wrap_err=1. Go to WRITE.
    - flags == 0 otherwise: stay in SCAN.
  - start is ignored in SCAN.
- WRITE (exactly one cycle):
  - ram_we=1.
  - ram_data = {zeros, seq, seg_start, end, eof}.
  - ram_addr = entry index.
  - Next edge:
    - entry_count+1 and ram_addr+1.
    - seg_start = end+1, truncated to ADDR_W.
    - seq+1.
  - Then:
    - if eof=1: go to DONE.
    - else if seq was 2^SEQ_W-1: set seq_ovf=1 and go to DONE.
    - else: go to SCAN.
  - start is ignored in WRITE.
- ram_we is 0 in every state except WRITE, so writes are single-cycle and never back-to-back.
- DONE: done=1. ram_data, entry_count and the error flags hold. Only start or reset leaves DONE.
- A single-word sequence (start == end) is legal.
- A flag on the first returned address after a flush is legal.
- Latency: a flag on address k of the first segment gives ram_we high on the cycle 2+k+ROM_LAT edges after the start edge. Between segments, the dead time from the write edge to re-issue is 1 cycle.

Test Plan:
- Defaults. ROM with end-of-seq at 3 and 7, end-of-ROM at 12 -> three writes:
  - ram_addr 0: seq 1, start 0, end 3, eof 0
  - ram_addr 1: seq 2, start 4, end 7, eof 0
  - ram_addr 2: seq 3, start 8, end 12, eof 1
  - Then done=1, entry_count=3.
- rom_flags=2'b11 at address 5 -> single entry: seq 1, start 0, end 5, eof 1. done=1, no further writes.
- No flags anywhere, ADDR_W=4 -> one entry: start 0, end 15, eof 1. wrap_err=1, done=1.
- SEQ_W=2, end-of-seq at every address -> entries with seq 1, 2, 3. Then seq_ovf=1, done=1, entry_count=3.
- ROM_LAT=1 and ROM_LAT=4 on the first stimulus -> identical ram_data/ram_addr sequence, with write timing per the latency formula. Addresses issued past a flag never produce entries.
- Reset=0 asserted in SCAN at address 6 -> outputs 0 immediately. A later start rescans from 0; a start pulse during SCAN has no effect.
